pixel_write_arbiter: RTL and testbench

- Shares the single VGA pixel-write port between N pixel-stream producers, e.g. rect renderer, character renderer and cursor/image renderer.
- Each producer sends a primitive as a stream of (x, y, color) beats; the final beat is flagged with last.
- Grants are primitive-atomic and rotate round-robin, so two primitives never interleave.
- Sits between the renderers and the VGA adapter. It replaces the enable-priority output mux in the page parser.

---
 rtl/pixel_write_arbiter_pkg.sv | 21 ++
 rtl/pixel_write_arbiter_if.sv | 33 +++
 rtl/pixel_write_arbiter_rr_picker.sv | 32 +++
 rtl/pixel_write_arbiter.sv | 127 ++++++++++++
 tb/tb_pixel_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants for the VGA pixel-write arbiter: screen geometry, pixel field
// widths, requester indices and the grant FSM encoding.
package pixel_write_arbiter_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;
    localparam int X_WIDTH       = 8;
    localparam int Y_WIDTH       = 7;
    localparam int COLOR_WIDTH   = 3;
    localparam int STALL_W       = 8;

    localparam int REQ_RECT = 0;
    localparam int REQ_TEXT = 1;
    localparam int REQ_IMG  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// Renderer-side beat streams plus the registered VGA write port.
// master = renderers/observer side, slave = arbiter side.
interface pixel_write_arbiter_if #(
    parameter int N     = 3,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int OWN_W = 2
);
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*X_W-1:0] req_x;
    logic [N*Y_W-1:0] req_y;
    logic [N*C_W-1:0] req_color;
    logic [N-1:0]     req_ready;

    logic [OWN_W-1:0] owner;
    logic             busy;
    logic [X_W-1:0]   out_x;
    logic [Y_W-1:0]   out_y;
    logic [C_W-1:0]   out_color;
    logic             plot;

    modport master (
        output req_valid, req_last, req_x, req_y, req_color,
        input  req_ready, owner, busy, out_x, out_y, out_color, plot
    );

    modport slave (
        input  req_valid, req_last, req_x, req_y, req_color,
        output req_ready, owner, busy, out_x, out_y, out_color, plot
    );
endinterface

// File: rtl/pixel_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid scanning ptr, ptr+1, ... mod N.
// Zero latency; no handshake of its own.
module pixel_write_arbiter_rr_picker #(
    parameter int N     = 3,
    parameter int OWN_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [OWN_W-1:0] ptr,
    output logic             found,
    output logic [OWN_W-1:0] idx
);
    logic [N-1:0]   rot;
    logic [OWN_W:0] sum;

    // Rotate so that bit k means requester (ptr+k) mod N; scan downward so the
    // lowest k (closest to the pointer) is the final winner.
    always_comb begin
        rot   = N'({valid, valid} >> ptr);
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (OWN_W + 1)'(k);
                if (sum >= (OWN_W + 1)'(N))
                    sum = sum - (OWN_W + 1)'(N);
                found = 1'b1;
                idx   = sum[OWN_W-1:0];
            end
        end
    end
endmodule

// File: rtl/pixel_write_arbiter.sv
// Primitive-atomic round-robin arbiter sharing the VGA pixel-write port; optional clip via PIXEL_WRITE_ARBITER_CLIP_EN.
// Latency: 1 cycle grant, accepted beat plotted the next cycle, 1 beat/cycle sustained.
// Backpressure: only the owner sees req_ready, and only while hold is low; a silent owner is revoked after TIMEOUT stalls.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int X_W      = X_WIDTH,
    parameter int Y_W      = Y_WIDTH,
    parameter int C_W      = COLOR_WIDTH,
    parameter int SCREEN_W = SCREEN_WIDTH,
    parameter int SCREEN_H = SCREEN_HEIGHT,
    parameter int TIMEOUT  = 255,
    parameter int OWN_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    pixel_write_arbiter_if.slave  bus
);
    if (N < 2 || N > 8 || OWN_W < 1 || OWN_W < $clog2(N) || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_cfg
        $error("pixel_write_arbiter: illegal parameter combination");
    end

    state_t             state, state_n;
    logic [OWN_W-1:0]   owner_q, owner_n, ptr, ptr_n, pick, next_ptr;
    logic [STALL_W-1:0] stall, stall_n;
    logic               found, xfer, revoke, in_bounds;
    logic               sel_vld, sel_last;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_c;

    pixel_write_arbiter_rr_picker #(.N(N), .OWN_W(OWN_W)) u_picker (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        sel_vld       = 1'b0;
        sel_last      = 1'b0;
        sel_x         = '0;
        sel_y         = '0;
        sel_c         = '0;
        bus.req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OWN_W'(i)) begin
                sel_vld  = bus.req_valid[i];
                sel_last = bus.req_last[i];
                sel_x    = bus.req_x[i*X_W +: X_W];
                sel_y    = bus.req_y[i*Y_W +: Y_W];
                sel_c    = bus.req_color[i*C_W +: C_W];
                bus.req_ready[i] = (state == ST_OWN) && !hold;
            end
        end
    end

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    // Off-screen beats still complete the handshake; they just never reach the VGA port.
    assign in_bounds = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
`else
    assign in_bounds = 1'b1;
`endif

    assign xfer     = (state == ST_OWN) && !hold && sel_vld;
    assign next_ptr = (owner_q == OWN_W'(N - 1)) ? '0 : owner_q + 1'b1;
    assign revoke   = (TIMEOUT != 0) && (state == ST_OWN) && !hold && !xfer
                      && (stall == STALL_W'(TIMEOUT));

    always_comb begin
        state_n = state;
        owner_n = owner_q;
        ptr_n   = ptr;
        stall_n = stall;
        case (state)
            ST_IDLE: begin
                stall_n = '0;
                if (!hold && found) begin
                    state_n = ST_OWN;
                    owner_n = pick;
                end
            end
            ST_OWN: begin
                if (xfer)
                    stall_n = '0;
                else if (!hold && !sel_vld && stall != {STALL_W{1'b1}})
                    stall_n = stall + 1'b1;
                if ((xfer && sel_last) || revoke) begin
                    state_n = ST_IDLE;
                    owner_n = '0;
                    ptr_n   = next_ptr;
                    stall_n = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner_q       <= '0;
            ptr           <= '0;
            stall         <= '0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.out_color <= '0;
            bus.plot      <= 1'b0;
        end else begin
            state    <= state_n;
            owner_q  <= owner_n;
            ptr      <= ptr_n;
            stall    <= stall_n;
            bus.plot <= xfer && in_bounds;
            if (xfer) begin
                bus.out_x     <= sel_x;
                bus.out_y     <= sel_y;
                bus.out_color <= sel_c;
            end
        end
    end

    assign bus.owner = owner_q;
    assign bus.busy  = (state == ST_OWN);
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter (N=3, TIMEOUT=4); clip checks run when PIXEL_WRITE_ARBITER_CLIP_EN is defined.
module tb_pixel_write_arbiter;
    import pixel_write_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic hold;
    int   total, bad;

    int en[3], nprim[3], nbeat[3], bcnt[3], pcnt[3], xbase[3], ybase[3], col[3];
    logic [17:0] exp_q[$];
    int pcyc[16];

    pixel_write_arbiter_if #(.N(3), .X_W(8), .Y_W(7), .C_W(3), .OWN_W(2)) bus ();

    pixel_write_arbiter #(.N(3), .TIMEOUT(4), .OWN_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .hold  (hold),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Producers: requester i sends nprim[i] primitives of nbeat[i] beats each.
    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            bus.req_valid[i]         = (en[i] != 0) && (pcnt[i] < nprim[i]);
            bus.req_last[i]          = (bcnt[i] == nbeat[i] - 1);
            bus.req_x[i*8 +: 8]      = 8'(xbase[i] + pcnt[i]);
            bus.req_y[i*7 +: 7]      = 7'(ybase[i] + bcnt[i]);
            bus.req_color[i*3 +: 3]  = 3'(col[i]);
        end
    endtask

    task automatic step();
        logic [2:0] acc;
        @(negedge clock);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
                if (bcnt[i] == nbeat[i] - 1) begin
                    bcnt[i] = 0;
                    pcnt[i]++;
                end else begin
                    bcnt[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1; nprim[i] = 0; nbeat[i] = 1; bcnt[i] = 0; pcnt[i] = 0;
            xbase[i] = 0; ybase[i] = 0; col[i] = 0;
        end
        drive();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [17:0] pix(input int x, input int y, input int c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction

    // Steps until every queued pixel has been plotted, recording the cycle of each plot.
    task automatic run_expect(input string tag, input int budget);
        int k;
        k = 0;
        for (int cyc = 0; cyc < budget && exp_q.size() > 0; cyc++) begin
            step();
            if (bus.plot) begin
                check(tag, {14'd0, bus.out_x, bus.out_y, bus.out_color}, {14'd0, exp_q.pop_front()});
                if (k < 16) pcyc[k] = cyc;
                k++;
            end
        end
        check({tag, "_all_plotted"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    int cx[3] = '{159, 160, 0};
    int cy[3] = '{119, 0, 120};

    task automatic set_beat(input int b);
        bus.req_valid[0]   = 1'b1;
        bus.req_last[0]    = (b == 2);
        bus.req_x[7:0]     = 8'(cx[b]);
        bus.req_y[6:0]     = 7'(cy[b]);
        bus.req_color[2:0] = 3'd4;
    endtask
`endif

    initial begin
        int n;
        total = 0;
        bad   = 0;

        // Reset state, with a request already pending
        reset = 1'b1;
        hold  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1; nprim[i] = 1; nbeat[i] = 1; bcnt[i] = 0; pcnt[i] = 0;
            xbase[i] = 7; ybase[i] = 7; col[i] = 7;
        end
        drive();
        repeat (2) @(posedge clock);
        #1;
        check("rst_owner", bus.owner, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_plot", bus.plot, 0);
        check("rst_out", {bus.out_x, bus.out_y, bus.out_color}, 0);
        check("rst_ready", bus.req_ready, 0);

        // Single 4-beat primitive from the text renderer
        do_reset();
        nprim[REQ_TEXT] = 1; nbeat[REQ_TEXT] = 4;
        xbase[REQ_TEXT] = 10; ybase[REQ_TEXT] = 5; col[REQ_TEXT] = 3;
        drive();
        #1;
        check("t1_idle_busy", bus.busy, 0);
        check("t1_idle_ready", bus.req_ready, 0);
        step();
        check("t1_owner", bus.owner, 1);
        check("t1_busy", bus.busy, 1);
        check("t1_ready", bus.req_ready, 3'b010);
        check("t1_no_early_plot", bus.plot, 0);
        for (int b = 0; b < 4; b++) exp_q.push_back(pix(10, 5 + b, 3));
        run_expect("t1_pix", 12);
        check("t1_consecutive", pcyc[3] - pcyc[0], 3);
        check("t1_busy_drop", bus.busy, 0);

        // Requesters 0 and 2 together: whole primitive of 0, one idle cycle, then 2
        do_reset();
        nprim[0] = 1; nbeat[0] = 3; xbase[0] = 20; col[0] = 1;
        nprim[2] = 1; nbeat[2] = 2; xbase[2] = 40; ybase[2] = 10; col[2] = 5;
        drive();
        exp_q.push_back(pix(20, 0, 1));
        exp_q.push_back(pix(20, 1, 1));
        exp_q.push_back(pix(20, 2, 1));
        exp_q.push_back(pix(40, 10, 5));
        exp_q.push_back(pix(40, 11, 5));
        run_expect("t2_pix", 20);
        check("t2_gap_a", pcyc[1] - pcyc[0], 1);
        check("t2_gap_b", pcyc[2] - pcyc[1], 1);
        check("t2_gap_idle", pcyc[3] - pcyc[2], 2);

        // Three requesters, three 1-beat primitives each: strict rotation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            nprim[i] = 3; nbeat[i] = 1; xbase[i] = 50 + 10 * i; col[i] = i + 1;
        end
        drive();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++) exp_q.push_back(pix(50 + 10 * i + p, 0, i + 1));
        run_expect("t3_order", 40);
        check("t3_spacing", pcyc[8] - pcyc[0], 16);

        // Owner 1 goes silent after one beat; requester 2 waits
        do_reset();
        nprim[1] = 1; nbeat[1] = 4; xbase[1] = 10; col[1] = 3;
        nprim[2] = 1; nbeat[2] = 1; xbase[2] = 40; col[2] = 5;
        drive();
        step();
        check("t4_owner1", bus.owner, 1);
        step();
        check("t4_first_plot", bus.plot, 1);
        check("t4_first_x", bus.out_x, 10);
        en[1] = 0;
        drive();
        n = 0;
        do begin
            step();
            n++;
        end while (bus.busy && n < 20);
        check("t4_revoke_cycles", n, 5);
        check("t4_revoke_owner", bus.owner, 0);
        check("t4_revoke_noplot", bus.plot, 0);
        step();
        check("t4_next_owner", bus.owner, 2);
        check("t4_next_busy", bus.busy, 1);
        step();
        check("t4_next_plot", bus.plot, 1);
        check("t4_next_x", bus.out_x, 40);

        // hold: no grant while idle, then a 10-cycle freeze mid-primitive
        do_reset();
        nprim[0] = 1; nbeat[0] = 4; xbase[0] = 30; col[0] = 2;
        hold = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            check("t5_hold_idle", bus.busy, 0);
        end
        hold = 1'b0;
        step();
        check("t5_granted", bus.busy, 1);
        step();
        step();
        hold  = 1'b1;
        en[0] = 0;
        drive();
        #1;
        check("t5_ready_off", bus.req_ready, 0);
        check("t5_inflight_plot", bus.plot, 1);
        check("t5_inflight_y", bus.out_y, 1);
        for (int c = 0; c < 10; c++) begin
            step();
            check("t5_hold_noplot", bus.plot, 0);
            check("t5_hold_busy", bus.busy, 1);
        end
        hold  = 1'b0;
        en[0] = 1;
        drive();
        exp_q.push_back(pix(30, 2, 2));
        exp_q.push_back(pix(30, 3, 2));
        run_expect("t5_resume", 10);
        check("t5_done", bus.busy, 0);

        // Asynchronous reset with a plot pending
        do_reset();
        nprim[0] = 1; nbeat[0] = 4; xbase[0] = 30; col[0] = 2;
        drive();
        step();
        step();
        check("t6_plot_before", bus.plot, 1);
        reset = 1'b1;
        #1;
        check("t6_plot_killed", bus.plot, 0);
        check("t6_busy_killed", bus.busy, 0);
        check("t6_out_cleared", bus.out_x, 0);

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
        do_reset();
        set_beat(0);
        step();
        set_beat(0);
        for (int b = 0; b < 3; b++) begin
            step();
            check("t7_clip_plot", bus.plot, (b == 0) ? 1 : 0);
            if (b == 0) check("t7_clip_x", bus.out_x, 159);
            if (b < 2) set_beat(b + 1);
            else       bus.req_valid[0] = 1'b0;
        end
        check("t7_clip_accepted", bus.busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
